// File: rtl/pl_pkg.sv
// Shared pipeline package for the RV32I core.
// Holds the writeback-source enum, the load funct3 codes and the
// MEM/WB pipeline register layout.
package pl_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_data;
    logic [31:0] ld_data;
    logic [2:0]  funct3;
    wb_sel_e     wb_sel;
    logic [4:0]  rd_addr;
    logic        rd_wren;
  } wb_reg_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment / extension (combinational).
// Ports:
//   ld_data  in  32  raw aligned word from the LSU
//   offset   in  2   byte offset within the word (address[1:0])
//   funct3   in  3   load size/sign code
//   ld_ext   out 32  selected and sign/zero-extended load value
module load_align
  import pl_pkg::*;
(
  input  logic [31:0] ld_data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ld_data[7:0];
    case (offset)
      2'd1:    byte_sel = ld_data[15:8];
      2'd2:    byte_sel = ld_data[23:16];
      2'd3:    byte_sel = ld_data[31:24];
      default: byte_sel = ld_data[7:0];
    endcase
  end

  // offset[0] is ignored for halfwords; misaligned accesses trap upstream.
  assign half_sel = offset[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    ld_ext = ld_data;  // lw and unused codes pass the word through
    case (funct3)
      F3_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ld_ext = {24'd0, byte_sel};
      F3_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ld_ext = {16'd0, half_sel};
      default: ld_ext = ld_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_pl.sv
// MEM/WB pipeline register and writeback stage.
// Captures MEM results, aligns load data, selects the writeback source
// and drives the register file write port. Emits a retire pulse and,
// when WB_RETIRE_CNT_EN is defined, a CNT_W-bit retired-instruction
// counter (otherwise o_retire_cnt is tied to 0).
// Ports:
//   i_clk, i_reset_n        clock, async active-low reset
//   i_mem_*                 MEM stage instruction fields
//   i_stall / i_flush       hold / bubble the WB register (flush wins)
//   o_rd_addr/data/wren     register file write port
//   o_wb_valid, o_wb_pc     WB entry status
//   o_retire, o_retire_cnt  retire pulse and count
module mem_wb_pl
  import pl_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_mem_valid,
  input  logic [31:0]      i_mem_pc,
  input  logic [31:0]      i_mem_alu_data,
  input  logic [31:0]      i_mem_ld_data,
  input  logic [2:0]       i_mem_funct3,
  input  logic [1:0]       i_mem_wb_sel,
  input  logic [4:0]       i_mem_rd_addr,
  input  logic             i_mem_rd_wren,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic             o_rd_wren,
  output logic             o_wb_valid,
  output logic [31:0]      o_wb_pc,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_retire_cnt
);

  wb_reg_t     wb_q;
  logic [31:0] ld_ext;

  // Flush only kills valid; the remaining fields are don't-care for a bubble.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_q <= '0;
    end else if (i_flush) begin
      wb_q.valid <= 1'b0;
    end else if (!i_stall) begin
      wb_q <= '{valid:    i_mem_valid,
                pc:       i_mem_pc,
                alu_data: i_mem_alu_data,
                ld_data:  i_mem_ld_data,
                funct3:   i_mem_funct3,
                wb_sel:   wb_sel_e'(i_mem_wb_sel),
                rd_addr:  i_mem_rd_addr,
                rd_wren:  i_mem_rd_wren};
    end
  end

  load_align u_load_align (
    .ld_data (wb_q.ld_data),
    .offset  (wb_q.alu_data[1:0]),
    .funct3  (wb_q.funct3),
    .ld_ext  (ld_ext)
  );

  always_comb begin
    o_rd_data = wb_q.alu_data;  // WB_ALU and reserved code
    case (wb_q.wb_sel)
      WB_LOAD: o_rd_data = ld_ext;
      WB_PC4:  o_rd_data = wb_q.pc + 32'd4;  // wraps mod 2^32
      default: o_rd_data = wb_q.alu_data;
    endcase
  end

  assign o_rd_addr  = wb_q.rd_addr;
  // Stays high while stalled: rewriting the same value is harmless.
  assign o_rd_wren  = wb_q.valid & wb_q.rd_wren & (wb_q.rd_addr != 5'd0);
  assign o_wb_valid = wb_q.valid;
  assign o_wb_pc    = wb_q.pc;
  assign o_retire   = wb_q.valid & ~i_stall;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)    cnt_q <= '0;
    else if (o_retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign o_retire_cnt = cnt_q;
`else
  assign o_retire_cnt = '0;
`endif

endmodule

// File: doc/mem_wb_pl.md
# mem_wb_pl

Memory/writeback pipeline register and writeback stage of the pipelined RV32I core. It captures MEM-stage results and aligns/sign-extends load data. It selects the writeback source and drives the register file write port (rd address, data, write enable) during the WB cycle. It also produces a retire pulse and an optional retired-instruction counter.

## Interface
- `CNT_W`, default 64: retired-instruction counter width.
- `i_clk`  in  1  global clock.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_mem_valid`  in  1  MEM stage holds a real instruction.
- `i_mem_pc`  in  32  PC of MEM instruction.
- `i_mem_alu_data`  in  32  ALU result; for loads, the byte address.
- `i_mem_ld_data`  in  32  raw aligned word returned by the LSU.
- `i_mem_funct3`  in  3  load size/sign code.
- `i_mem_wb_sel`  in  2  writeback source: 0 ALU, 1 load, 2 PC+4, 3 reserved (ALU).
- `i_mem_rd_addr`  in  5  destination register.
- `i_mem_rd_wren`  in  1  instruction writes rd.
- `i_stall`  in  1  hold WB register contents.
- `i_flush`  in  1  replace next WB entry with bubble.
- `o_rd_addr`  out  5  register file write address.
- `o_rd_data`  out  32  register file write data.
- `o_rd_wren`  out  1  register file write enable.
- `o_wb_valid`  out  1  WB register holds a real instruction.
- `o_wb_pc`  out  32  PC of WB instruction.
- `o_retire`  out  1  instruction leaves WB this cycle.
- `o_retire_cnt`  out  CNT_W  retired-instruction count.

## Operation
- WB register fields: valid, pc, alu_data, ld_data, funct3, wb_sel, rd_addr, rd_wren.
- Per posedge, priority order:
  - `i_flush`: valid←0, other fields don't-care.
  - else `i_stall`: hold all fields.
  - else load all fields from MEM inputs.
- Flush beats stall when both are asserted.
- Load alignment, combinational from WB register. Byte offset is `alu_data[1:0]`.
  - 000 lb: byte[off], sign-extended.
  - 100 lbu: byte[off], zero-extended.
  - 001 lh: halfword[off[1]], sign-extended.
  - 101 lhu: halfword[off[1]], zero-extended.
  - 010 lw, and codes 011/110/111: full word, offset ignored.
  - `off[0]` is ignored for halfwords; misalignment is trapped upstream.
- Writeback data select:
  - wb_sel 1: aligned load data.
  - wb_sel 2: pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - wb_sel 0 and 3: alu_data.
- `o_rd_wren = valid & rd_wren & (rd_addr != 0)`.
- `o_rd_addr`/`o_rd_data` are driven regardless of wren.
- `o_retire = valid & ~i_stall`.
- Counter increments by 1 when `o_retire` is high. It wraps from all-ones to 0.

## Timing
- MEM inputs presented in cycle N appear on the outputs in cycle N+1 (one register stage).
- The register file commits at the end of N+1; its bypass covers same-cycle ID reads.
- While stalled, `o_rd_wren` stays asserted with identical data (idempotent rewrite). `o_retire` stays low.
- A flushed entry never asserts `o_rd_wren` or `o_retire`.
- Reset asserted: immediately (asynchronous) all WB fields, all outputs, and the counter are 0.
- Reset deassertion: the first capture occurs at the next posedge after `i_reset_n` rises.
- Reset mid-stall or mid-flush: reset wins.

## Configuration
- `WB_RETIRE_CNT_EN` defined: `o_retire_cnt` is a CNT_W-bit counter as described.
- `WB_RETIRE_CNT_EN` undefined: no counter flops; `o_retire_cnt` is tied to 0.
- `o_retire` is present in both builds.

## Structure
- Shared package `pl_pkg` holds:
  - `wb_sel_e` enum (WB_ALU, WB_LOAD, WB_PC4, WB_RSVD).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - The WB register struct typedef.
- One combinational sub-module `load_align`: inputs ld_data, offset, funct3; output 32-bit extended data.

## Test plan
- lb, ld_data=0x80FF7F01, alu_data=0x1003, rd=5 → next cycle `o_rd_data`=0xFFFFFF80, `o_rd_wren`=1, `o_rd_addr`=5.
- lhu/lh, ld_data=0x8001ABCD, offset 2:
  - lhu → 0x00008001.
  - lh → 0xFFFF8001.
  - lw → 0x8001ABCD.
- wb_sel=2, pc=0xFFFFFFFC → `o_rd_data`=0x00000000.
- rd_addr=0 with rd_wren=1 → `o_rd_wren`=0, `o_retire`=1.
- Stall and flush:
  - valid instruction, then `i_stall`=1 for 3 cycles → outputs held, `o_retire`=0 throughout, counter unchanged; `o_retire`=1 on release.
  - `i_stall`=`i_flush`=1 → bubble loaded, `o_wb_valid`=0.
- Counter and reset:
  - 10 back-to-back valid instructions → `o_retire_cnt`=10.
  - Assert `i_reset_n`=0 mid-stream → all outputs 0 immediately, before the next clock edge.
  - With `WB_RETIRE_CNT_EN` undefined, `o_retire_cnt` stays 0.
